// File: rtl/mvprod_seq_if.sv
// Handshake/bus bundle between mvprod_seq and its upstream stream, VecFIFOs,
// MVProd core and downstream stream. master = sequencer side, slave = surroundings.
interface mvprod_seq_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       ififo_wr_en;
   logic [7:0] ififo_wr_data;
   logic       mv_start;
   logic       mv_done;
   logic       ofifo_wrap_rd;
   logic       ofifo_rd_en;
   logic [7:0] ofifo_rd_data;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
   logic       busy;
   logic       vec_done;
   logic       timeout_err;

   modport master (
      input  s_valid, s_data, mv_done, ofifo_rd_data, m_ready,
      output s_ready, ififo_wr_en, ififo_wr_data, mv_start, ofifo_wrap_rd,
             ofifo_rd_en, m_valid, m_data, busy, vec_done, timeout_err
   );

   modport slave (
      output s_valid, s_data, mv_done, ofifo_rd_data, m_ready,
      input  s_ready, ififo_wr_en, ififo_wr_data, mv_start, ofifo_wrap_rd,
             ofifo_rd_en, m_valid, m_data, busy, vec_done, timeout_err
   );
endinterface

// File: rtl/mvprod_seq.sv
// Sequencer: loads one input vector into the VecFIFO, kicks MVProd, drains the result.
// Optional compute watchdog with ERR state enabled by macro MVPROD_SEQ_TIMEOUT_EN.
module mvprod_seq #(
   parameter int VecElements   = 8,
   parameter int OutVecLength  = 8,
   parameter int TimeoutCycles = 1024
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   mvprod_seq_if.master bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      START   = 3'd2,
      COMPUTE = 3'd3,
      WRAP    = 3'd4,
      DRAIN   = 3'd5
`ifdef MVPROD_SEQ_TIMEOUT_EN
      , ERR   = 3'd6
`endif
   } state_t;

   localparam logic [7:0] IN_LAST  = 8'(VecElements - 1);
   localparam logic [7:0] OUT_LAST = 8'(OutVecLength - 1);

   if (VecElements < 1 || VecElements > 255) begin : g_bad_vec
      $error("mvprod_seq: VecElements out of range 1..255");
   end
   if (OutVecLength < 1 || OutVecLength > 255) begin : g_bad_out
      $error("mvprod_seq: OutVecLength out of range 1..255");
   end
   if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_to
      $error("mvprod_seq: TimeoutCycles out of range 1..65535");
   end

   state_t     state_r, state_s;
   logic [7:0] in_cnt_r, out_cnt_r;
   logic       vec_done_r;
   logic       s_ready_s, wr_en_s, mv_start_s, wrap_s, rd_en_s, m_valid_s, busy_s, last_out_s;
   logic [7:0] wr_data_s, m_data_s;

`ifdef MVPROD_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TimeoutCycles - 1);
   logic [15:0] wd_r;
`endif

   // Next-state and per-state output decode.
   always_comb begin
      state_s    = state_r;
      s_ready_s  = 1'b0;
      wr_en_s    = 1'b0;
      wr_data_s  = 8'd0;
      mv_start_s = 1'b0;
      wrap_s     = 1'b0;
      rd_en_s    = 1'b0;
      m_valid_s  = 1'b0;
      m_data_s   = 8'd0;
      busy_s     = 1'b1;
      last_out_s = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s    = 1'b0;
            s_ready_s = 1'b1;
            // Gated by reset so no write leaks out while rst_n_in is low.
            wr_en_s   = bus.s_valid && rst_n_in;
            wr_data_s = rst_n_in ? bus.s_data : 8'd0;
            if (wr_en_s) begin
               state_s = (VecElements == 1) ? START : LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            s_ready_s = 1'b1;
            wr_en_s   = bus.s_valid;
            wr_data_s = bus.s_data;
            if (bus.s_valid && (in_cnt_r == IN_LAST)) begin
               state_s = START;
            end else begin
               state_s = LOAD;
            end
         end
         START: begin
            mv_start_s = 1'b1;
            state_s    = COMPUTE;
         end
         COMPUTE: begin
            if (bus.mv_done) begin
               state_s = WRAP;
`ifdef MVPROD_SEQ_TIMEOUT_EN
            end else if (wd_r == TO_LAST) begin
               state_s = ERR;
`endif
            end else begin
               state_s = COMPUTE;
            end
         end
         WRAP: begin
            wrap_s  = 1'b1;
            state_s = DRAIN;
         end
         DRAIN: begin
            m_valid_s = 1'b1;
            m_data_s  = bus.ofifo_rd_data;
            rd_en_s   = bus.m_ready;
            if (bus.m_ready && (out_cnt_r == OUT_LAST)) begin
               last_out_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
`ifdef MVPROD_SEQ_TIMEOUT_EN
         ERR: begin
            state_s = ERR;
         end
`endif
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, byte counters and the registered completion pulse.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r    <= IDLE;
         in_cnt_r   <= 8'd0;
         out_cnt_r  <= 8'd0;
         vec_done_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         vec_done_r <= last_out_s;
         if (state_r == IDLE) begin
            in_cnt_r <= wr_en_s ? 8'd1 : 8'd0;
         end else if ((state_r == LOAD) && wr_en_s) begin
            in_cnt_r <= in_cnt_r + 8'd1;
         end else begin
            in_cnt_r <= in_cnt_r;
         end
         if (state_r == IDLE) begin
            out_cnt_r <= 8'd0;
         end else if (rd_en_s) begin
            out_cnt_r <= out_cnt_r + 8'd1;
         end else begin
            out_cnt_r <= out_cnt_r;
         end
      end
   end

`ifdef MVPROD_SEQ_TIMEOUT_EN
   // Watchdog counts consecutive COMPUTE cycles and restarts outside COMPUTE.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wd_r <= 16'd0;
      end else if (state_r == COMPUTE) begin
         wd_r <= wd_r + 16'd1;
      end else begin
         wd_r <= 16'd0;
      end
   end

   assign bus.timeout_err = (state_r == ERR);
`else
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.s_ready       = s_ready_s;
   assign bus.ififo_wr_en   = wr_en_s;
   assign bus.ififo_wr_data = wr_data_s;
   assign bus.mv_start      = mv_start_s;
   assign bus.ofifo_wrap_rd = wrap_s;
   assign bus.ofifo_rd_en   = rd_en_s;
   assign bus.m_valid       = m_valid_s;
   assign bus.m_data        = m_data_s;
   assign bus.busy          = busy_s;
   assign bus.vec_done      = vec_done_r;
endmodule
